// File: rtl/bin2gray_pkg.sv
// bin2gray_pkg: shared Gray-code helpers for FIFO pointer conversion
package bin2gray_pkg;
  localparam int GRAY_DEFAULT_WIDTH = 8;
  localparam int GRAY_MAX_WIDTH = 32;
  // Callers zero-extend narrower pointers into the argument and cast the result back down
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin_to_gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/bin2gray_gray_step_check.sv
// gray_step_check: flags a Gray update that moves more than one bit
module gray_step_check #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_prev,
  output logic             o_multi
);
  logic [WIDTH-1:0] w_diff;
  // Distance 0 and 1 are legal pointer steps; anything wider is a broken update
  always_comb begin
    w_diff  = i_cur ^ i_prev;
    o_multi = $countones(w_diff) > 1;
  end
endmodule

// File: rtl/bin2gray.sv
// bin2gray: combinational Gray conversion plus a registered CDC launch copy with step checking
module bin2gray
  import bin2gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  input  logic             en,
  output logic [WIDTH-1:0] gray_q,
  output logic             gray_vld,
  output logic             step_err
);
  logic [WIDTH-1:0] r_gray_q;
  logic             r_vld;
  logic             r_err;
  logic             w_multi;
  // Zero-latency conversion; truncating back to WIDTH drops only zero-extended bits
  always_comb gray = WIDTH'(bin_to_gray(GRAY_MAX_WIDTH'(bin)));
  gray_step_check #(.WIDTH(WIDTH)) u_step (
    .i_cur  (gray),
    .i_prev (r_gray_q),
    .o_multi(w_multi)
  );
  // Launch register: reset wins over a coincident load, pulses only follow a load edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray_q <= '0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_vld <= en;
      r_err <= en & w_multi;
      if (en) r_gray_q <= gray;
    end
  end
  assign gray_q   = r_gray_q;
  assign gray_vld = r_vld;
  assign step_err = r_err;
endmodule

// File: tb/tb_bin2gray.sv
// tb_bin2gray: directed self-checking bench for bin2gray at WIDTH=8
module tb_bin2gray;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] bin = 8'h00;
  logic [7:0] gray, gray_q;
  logic       gray_vld, step_err;
  int         total = 0;
  int         bad = 0;

  bin2gray #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bin(bin), .gray(gray), .en(en),
    .gray_q(gray_q), .gray_vld(gray_vld), .step_err(step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_gray(input logic [7:0] b);
    logic [7:0] g;
    g[7] = b[7];
    for (int k = 0; k < 7; k++) g[k] = b[k+1] ^ b[k];
    return g;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      bin = 8'(i);
      #1;
      chk("sweep", 32'(gray), 32'(ref_gray(8'(i))));
    end
    bin = 8'h00; #1; chk("spot00", 32'(gray), 32'h00);
    bin = 8'h01; #1; chk("spot01", 32'(gray), 32'h01);
    bin = 8'h02; #1; chk("spot02", 32'(gray), 32'h03);
    bin = 8'h7F; #1; chk("spot7f", 32'(gray), 32'h40);
    bin = 8'h80; #1; chk("spot80", 32'(gray), 32'hC0);
    bin = 8'hFF; #1; chk("spotff", 32'(gray), 32'h80);

    @(negedge clk);
    rst = 1'b1; en = 1'b1; bin = 8'hAA;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(gray_q), 32'h0);
    chk("rst_vld", 32'(gray_vld), 32'h0);
    chk("rst_err", 32'(step_err), 32'h0);
    chk("rst_gray", 32'(gray), 32'hFF);

    rst = 1'b0; bin = 8'h05; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("load_q", 32'(gray_q), 32'h07);
    chk("load_vld", 32'(gray_vld), 32'h1);
    @(negedge clk);
    chk("hold_vld", 32'(gray_vld), 32'h0);
    chk("hold_q", 32'(gray_q), 32'h07);
    chk("hold_err", 32'(step_err), 32'h0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      bin = 8'(i);
      @(negedge clk);
      chk("inc_err", 32'(step_err), 32'h0);
    end
    chk("wrap_q", 32'(gray_q), 32'h00);
    chk("wrap_vld", 32'(gray_vld), 32'h1);

    bin = 8'h05;
    @(negedge clk);
    chk("jump_err", 32'(step_err), 32'h1);
    chk("jump_q", 32'(gray_q), 32'h07);
    @(negedge clk);
    chk("reload_err", 32'(step_err), 32'h0);
    en = 1'b0;
    @(negedge clk);
    chk("idle_err", 32'(step_err), 32'h0);
    chk("idle_vld", 32'(gray_vld), 32'h0);

    bin = 8'h10; en = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_q", 32'(gray_q), 32'h0);
    chk("mid_rst_vld", 32'(gray_vld), 32'h0);
    chk("mid_rst_err", 32'(step_err), 32'h0);
    rst = 1'b0; bin = 8'h01;
    @(negedge clk);
    en = 1'b0;
    chk("post_rst_err", 32'(step_err), 32'h0);
    chk("post_rst_q", 32'(gray_q), 32'h01);
    chk("post_rst_vld", 32'(gray_vld), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
